// File: rtl/risc16_mem_arbiter_if.sv
// Bus bundle between the risc16f fetch/data ports, the arbiter and the single-port SRAM.
// The slave modport is the arbiter's view; the master modport is the CPU and SRAM side.
interface risc16_mem_arbiter_if;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [15:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [15:0] d_rdata;
  logic        m_en;
  logic        m_we;
  logic [14:0] m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_en, m_we, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/risc16_mem_arbiter.sv
// Shares one single-port SRAM between the risc16f fetch and data ports (data first, with a
// fetch starvation guard) and hosts the two-word LED register window on the data port.
module risc16_mem_arbiter #(
  parameter logic [3:0]  STARVE_MAX = 4'd4,
  parameter logic [15:0] IO_BASE    = 16'h0200
) (
  input  logic                        clk,
  input  logic                        rst_n,
  risc16_mem_arbiter_if.slave         bus,
  output logic [23:0]                 led
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DMEM = 2'd1,
    OWN_DIO  = 2'd2
  } d_owner_e;

  d_owner_e    d_owner_q, d_owner_d;
  logic        i_pend_q, i_pend_d;
  logic [3:0]  starve_q, starve_d;
  logic [23:0] led_q, led_d;
  logic [15:0] io_rdata_q, io_rdata_d;

  logic d_io_s, d_mem_s, starve_hit_s;
  logic i_gnt_s, d_gnt_s, dmem_gnt_s;
  logic unused_s;

  assign unused_s     = bus.i_addr[0] ^ bus.d_addr[0];
  assign d_io_s       = bus.d_req & (bus.d_addr[15:2] == IO_BASE[15:2]);
  assign d_mem_s      = bus.d_req & ~d_io_s;
  assign starve_hit_s = (starve_q == STARVE_MAX);

  // Grants and SRAM drive; everything is held off while reset is asserted.
  always_comb begin
    i_gnt_s     = 1'b0;
    d_gnt_s     = 1'b0;
    dmem_gnt_s  = 1'b0;
    bus.m_en    = 1'b0;
    bus.m_we    = 1'b0;
    bus.m_addr  = bus.i_addr[15:1];
    bus.m_wdata = bus.d_wdata;
    if (rst_n) begin
      d_gnt_s    = d_io_s | (d_mem_s & ~(bus.i_req & starve_hit_s));
      i_gnt_s    = bus.i_req & ~(d_mem_s & ~starve_hit_s);
      dmem_gnt_s = d_gnt_s & d_mem_s;
      bus.m_en   = dmem_gnt_s | i_gnt_s;
      bus.m_we   = dmem_gnt_s & bus.d_we;
      if (dmem_gnt_s) begin
        bus.m_addr = bus.d_addr[15:1];
      end else begin
        bus.m_addr = bus.i_addr[15:1];
      end
    end else begin
      bus.m_addr = bus.i_addr[15:1];
    end
  end

  assign bus.i_gnt = i_gnt_s;
  assign bus.d_gnt = d_gnt_s;

  // Next state: starvation counter, read-return owners, LED registers and IO read latch.
  always_comb begin
    starve_d   = starve_q;
    i_pend_d   = i_gnt_s;
    d_owner_d  = OWN_NONE;
    led_d      = led_q;
    io_rdata_d = io_rdata_q;
    if (i_gnt_s) begin
      starve_d = 4'd0;
    end else if (bus.i_req && !starve_hit_s) begin
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = starve_q;
    end
    if (d_gnt_s && !bus.d_we) begin
      d_owner_d = d_io_s ? OWN_DIO : OWN_DMEM;
    end else begin
      d_owner_d = OWN_NONE;
    end
    if (d_gnt_s && d_io_s) begin
      // The read latch captures LED contents from before any same-cycle write.
      if (bus.d_we) begin
        if (bus.d_addr[1]) begin
          led_d[23:16] = bus.d_wdata[7:0];
        end else begin
          led_d[15:0] = bus.d_wdata;
        end
      end else begin
        io_rdata_d = bus.d_addr[1] ? {8'h00, led_q[23:16]} : led_q[15:0];
      end
    end else begin
      led_d = led_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q   <= 4'd0;
      i_pend_q   <= 1'b0;
      d_owner_q  <= OWN_NONE;
      led_q      <= 24'h000000;
      io_rdata_q <= 16'h0000;
    end else begin
      starve_q   <= starve_d;
      i_pend_q   <= i_pend_d;
      d_owner_q  <= d_owner_d;
      led_q      <= led_d;
      io_rdata_q <= io_rdata_d;
    end
  end

  // Read return; data buses are zero whenever their valid is low.
  always_comb begin
    bus.i_rvalid = i_pend_q;
    bus.i_rdata  = i_pend_q ? bus.m_rdata : 16'h0000;
    bus.d_rvalid = 1'b0;
    bus.d_rdata  = 16'h0000;
    case (d_owner_q)
      OWN_DMEM: begin
        bus.d_rvalid = 1'b1;
        bus.d_rdata  = bus.m_rdata;
      end
      OWN_DIO: begin
        bus.d_rvalid = 1'b1;
        bus.d_rdata  = io_rdata_q;
      end
      default: begin
        bus.d_rvalid = 1'b0;
        bus.d_rdata  = 16'h0000;
      end
    endcase
  end

  assign led = led_q;

endmodule

// File: tb/tb_risc16_mem_arbiter.sv
// Directed bench for risc16_mem_arbiter with a behavioural one-cycle-latency SRAM.
module tb_risc16_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] led;
  logic [15:0] mem [0:255];
  int          n_assert = 0;
  int          n_fail = 0;

  risc16_mem_arbiter_if bus ();

  risc16_mem_arbiter #(.STARVE_MAX(4'd4), .IO_BASE(16'h0200)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .led   (led)
  );

  always #5 clk = ~clk;

  // SRAM model: synchronous write, read data registered for the following cycle.
  always @(posedge clk) begin
    if (bus.m_en) begin
      if (bus.m_we) mem[bus.m_addr[7:0]] <= bus.m_wdata;
      else          bus.m_rdata <= mem[bus.m_addr[7:0]];
    end
  end

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic exp_i, prev_i;
    for (int k = 0; k < 256; k++) mem[k] = 16'h0000;
    mem[8'h20] = 16'hA5C3;
    bus.m_rdata = 16'h0000;
    rst_n = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 16'h0040;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0010; bus.d_wdata = 16'h0000;
    #1;
    chk("rst_i_gnt", {23'd0, bus.i_gnt}, 24'd0);
    chk("rst_d_gnt", {23'd0, bus.d_gnt}, 24'd0);
    chk("rst_m_en",  {23'd0, bus.m_en},  24'd0);
    step(); step();
    chk("rst_led", led, 24'h000000);
    chk("rst_i_rvalid", {23'd0, bus.i_rvalid}, 24'd0);
    chk("rst_d_rvalid", {23'd0, bus.d_rvalid}, 24'd0);
    bus.i_req = 1'b0; bus.d_req = 1'b0; rst_n = 1'b1;
    step();

    // Instruction fetch with one-cycle return.
    bus.i_req = 1'b1; bus.i_addr = 16'h0040;
    #1;
    chk("t2_i_gnt",  {23'd0, bus.i_gnt}, 24'd1);
    chk("t2_m_en",   {23'd0, bus.m_en},  24'd1);
    chk("t2_m_we",   {23'd0, bus.m_we},  24'd0);
    chk("t2_m_addr", {9'd0, bus.m_addr}, 24'h000020);
    step();
    bus.i_req = 1'b0;
    chk("t2_i_rvalid", {23'd0, bus.i_rvalid}, 24'd1);
    chk("t2_i_rdata",  {8'd0, bus.i_rdata},  24'h00A5C3);
    chk("t2_d_rdata0", {8'd0, bus.d_rdata},  24'h000000);
    step();
    chk("t2_i_rvalid_off", {23'd0, bus.i_rvalid}, 24'd0);
    chk("t2_i_rdata_off",  {8'd0, bus.i_rdata},  24'h000000);

    // LED register writes and readback.
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0200; bus.d_wdata = 16'h1234;
    #1;
    chk("t3_d_gnt", {23'd0, bus.d_gnt}, 24'd1);
    chk("t3_m_en",  {23'd0, bus.m_en},  24'd0);
    step();
    chk("t3_led0", led, 24'h001234);
    bus.d_addr = 16'h0202; bus.d_wdata = 16'hFF56;
    step();
    chk("t3_led1", led, 24'h561234);
    chk("t3_wr_no_rvalid", {23'd0, bus.d_rvalid}, 24'd0);
    bus.d_we = 1'b0; bus.d_addr = 16'h0202;
    step();
    bus.d_req = 1'b0;
    chk("t3_d_rvalid", {23'd0, bus.d_rvalid}, 24'd1);
    chk("t3_d_rdata",  {8'd0, bus.d_rdata},  24'h000056);
    step();
    chk("t3_d_rvalid_off", {23'd0, bus.d_rvalid}, 24'd0);

    // Sustained conflict: fetch wins every fifth cycle.
    bus.i_req = 1'b1; bus.i_addr = 16'h0040;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0010;
    prev_i = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      #1;
      exp_i = (c == 5) || (c == 10);
      chk($sformatf("t4_i_gnt_c%0d", c), {23'd0, bus.i_gnt}, {23'd0, exp_i});
      chk($sformatf("t4_d_gnt_c%0d", c), {23'd0, bus.d_gnt}, {23'd0, ~exp_i});
      if (c > 1) begin
        chk($sformatf("t4_i_rvalid_c%0d", c), {23'd0, bus.i_rvalid}, {23'd0, prev_i});
        chk($sformatf("t4_d_rvalid_c%0d", c), {23'd0, bus.d_rvalid}, {23'd0, ~prev_i});
      end
      prev_i = exp_i;
      @(posedge clk);
      #1;
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    #1;
    step();

    // Fetch and IO read granted together.
    bus.i_req = 1'b1; bus.i_addr = 16'h0040;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0200;
    #1;
    chk("t5_i_gnt",  {23'd0, bus.i_gnt}, 24'd1);
    chk("t5_d_gnt",  {23'd0, bus.d_gnt}, 24'd1);
    chk("t5_m_addr", {9'd0, bus.m_addr}, 24'h000020);
    step();
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    chk("t5_i_rvalid", {23'd0, bus.i_rvalid}, 24'd1);
    chk("t5_i_rdata",  {8'd0, bus.i_rdata},  24'h00A5C3);
    chk("t5_d_rvalid", {23'd0, bus.d_rvalid}, 24'd1);
    chk("t5_d_rdata",  {8'd0, bus.d_rdata},  24'h001234);
    step();

    // Reset lands on the edge closing a read grant.
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0010;
    #1;
    chk("t6_d_gnt", {23'd0, bus.d_gnt}, 24'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_d_gnt_rst", {23'd0, bus.d_gnt}, 24'd0);
    step();
    bus.d_req = 1'b0;
    chk("t6_d_rvalid_rst", {23'd0, bus.d_rvalid}, 24'd0);
    chk("t6_led_rst", led, 24'h000000);
    rst_n = 1'b1;
    step();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0010; bus.d_wdata = 16'hBEEF;
    #1;
    chk("t6_m_we",   {23'd0, bus.m_we},  24'd1);
    chk("t6_m_addr", {9'd0, bus.m_addr}, 24'h000008);
    step();
    chk("t6_wr_no_rvalid", {23'd0, bus.d_rvalid}, 24'd0);
    bus.d_we = 1'b0;
    #1;
    chk("t6_rd_gnt", {23'd0, bus.d_gnt}, 24'd1);
    step();
    bus.d_req = 1'b0;
    chk("t6_d_rvalid", {23'd0, bus.d_rvalid}, 24'd1);
    chk("t6_d_rdata",  {8'd0, bus.d_rdata},  24'h00BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
